// File: rtl/dpi_timing_generator.sv
// Pi-side DPI output timing: an 864x625 raster advanced on the sysClkPhase pixel strobe,
// with registered sync/enable/coordinate outputs and genlock realignment to pixel (0,0).
module dpi_timing_generator #(
  parameter logic [2:0] PIXEL_PHASE = 3'd0,
  parameter int         H_ACTIVE    = 720,
  parameter int         H_FP        = 12,
  parameter int         H_SYNC      = 64,
  parameter int         H_BP        = 68,
  parameter int         V_ACTIVE    = 576,
  parameter int         V_FP        = 5,
  parameter int         V_SYNC      = 5,
  parameter int         V_BP        = 39
) (
  input  logic       sysClk,
  input  logic       nReset,
  input  logic [2:0] sysClkPhase,
  input  logic       genlock_req,
  output logic       pixel_tick,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       display_enable,
  output logic       frame_start_flag,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       genlock_pending
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       tick;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       genlock_pending_q, genlock_pending_d;
  logic       pixel_tick_q, pixel_tick_d;
  logic       hsync_n_q, hsync_n_d;
  logic       vsync_n_q, vsync_n_d;
  logic       display_enable_q, display_enable_d;
  logic       frame_start_q, frame_start_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       active_next;
  logic       hsync_region;
  logic       vsync_region;

  assign tick = (sysClkPhase == PIXEL_PHASE);

  // A pending genlock overrides the natural advance, so a request landing on the
  // natural frame wrap still yields a single (0,0) and a single frame start.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (genlock_pending_q) begin
        h_cnt_d = '0;
        v_cnt_d = '0;
      end else if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // A request sampled on a tick edge is held over for the following tick.
  always_comb begin
    genlock_pending_d = genlock_req | (genlock_pending_q & ~tick);
  end

  always_comb begin
    active_next      = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    hsync_region     = (h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST);
    vsync_region     = (v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST);
    pixel_tick_d     = tick;
    hsync_n_d        = hsync_n_q;
    vsync_n_d        = vsync_n_q;
    display_enable_d = display_enable_q;
    pixel_x_d        = pixel_x_q;
    pixel_y_d        = pixel_y_q;
    frame_start_d    = 1'b0;
    if (tick) begin
      hsync_n_d        = ~hsync_region;
      vsync_n_d        = ~vsync_region;
      display_enable_d = active_next;
      pixel_x_d        = active_next ? h_cnt_d : '0;
      pixel_y_d        = active_next ? v_cnt_d : '0;
      frame_start_d    = (h_cnt_d == '0) && (v_cnt_d == '0);
    end
  end

  // Counters park at the last dot of the last line so the first tick opens a frame.
  always_ff @(posedge sysClk or negedge nReset) begin
    if (!nReset) begin
      h_cnt_q           <= H_LAST;
      v_cnt_q           <= V_LAST;
      genlock_pending_q <= 1'b0;
      pixel_tick_q      <= 1'b0;
      hsync_n_q         <= 1'b1;
      vsync_n_q         <= 1'b1;
      display_enable_q  <= 1'b0;
      frame_start_q     <= 1'b0;
      pixel_x_q         <= '0;
      pixel_y_q         <= '0;
    end else begin
      h_cnt_q           <= h_cnt_d;
      v_cnt_q           <= v_cnt_d;
      genlock_pending_q <= genlock_pending_d;
      pixel_tick_q      <= pixel_tick_d;
      hsync_n_q         <= hsync_n_d;
      vsync_n_q         <= vsync_n_d;
      display_enable_q  <= display_enable_d;
      frame_start_q     <= frame_start_d;
      pixel_x_q         <= pixel_x_d;
      pixel_y_q         <= pixel_y_d;
    end
  end

  assign pixel_tick       = pixel_tick_q;
  assign hsync_n          = hsync_n_q;
  assign vsync_n          = vsync_n_q;
  assign display_enable   = display_enable_q;
  assign frame_start_flag = frame_start_q;
  assign pixel_x          = pixel_x_q;
  assign pixel_y          = pixel_y_q;
  assign genlock_pending  = genlock_pending_q;

endmodule
